// File: rtl/atable_pkg.sv
// Shared types and helpers for the attribute-table quad writer.
// Holds the FSM state encoding, geometry constants and the tile->byte/field decode.
// Attribute byte address = {nametable, row/4, col/4}; field index = {row bit1, col bit1}.
package atable_pkg;

   localparam int AW      = 7;
   localparam int MAX_ROW = 29;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WAIT = 2'd2,
      WR   = 2'd3
   } state_t;

   // Quadrant inside the 32x32-pixel attribute cell: bit1 = bottom half, bit0 = right half.
   function automatic logic [1:0] quad_of(input logic row_b1, input logic col_b1);
      return {row_b1, col_b1};
   endfunction

   // Byte address of the attribute cell covering a tile; callers pass tile row/col bits [4:2].
   function automatic logic [AW-1:0] addr_of(input logic nt, input logic [2:0] row_hi,
                                             input logic [2:0] col_hi);
      return {nt, row_hi, col_hi};
   endfunction

endpackage

// File: rtl/atable_field_merge.sv
// Replaces one 2-bit palette field of an attribute byte, preserving the other six bits.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module atable_field_merge (
   input  logic [7:0] i_byte,
   input  logic [1:0] i_q,
   input  logic [1:0] i_pal,
   output logic [7:0] o_byte
);

   // Overwrite bits [2q+1:2q] with the new palette select.
   always_comb begin
      o_byte = i_byte;
      o_byte[{i_q, 1'b0} +: 2] = i_pal;
   end

endmodule

// File: rtl/atable_quad_writer.sv
// Read-modify-write of one tile's 2-bit palette field in the 128-byte attribute RAM.
// Latency: accept N, read strobe N+1, data N+2, write + done N+3, ready again N+4.
// Backpressure: req_ready only in IDLE, one operation in flight; optional macro ATABLE_SKIP_SAME_EN.
module atable_quad_writer #(
   parameter int AW      = atable_pkg::AW,
   parameter int MAX_ROW = atable_pkg::MAX_ROW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_nt,
   input  logic [4:0]    req_col,
   input  logic [4:0]    req_row,
   input  logic [1:0]    req_pal,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_en,
   input  logic [7:0]    mem_rdata,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   output logic          done,
   output logic          err
);

   import atable_pkg::*;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [1:0]    r_q;
   logic [1:0]    r_pal;
   logic [7:0]    r_merged;
   logic          r_err;
   logic          w_accept;
   logic          w_reject;
   logic [7:0]    w_merged;
   logic          w_unused_col0;

   // Column bit 0 selects a pixel half inside a quadrant and never affects the field.
   assign w_unused_col0 = req_col[0];

   // Ready is forced high during reset so the reset-state view is IDLE immediately.
   assign req_ready = rst || (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;
   assign w_reject  = w_accept && (int'(req_row) > MAX_ROW);

   assign mem_addr  = r_addr;
   assign mem_wdata = r_merged;
   assign err       = r_err && !rst;

   atable_field_merge u_merge (
      .i_byte (mem_rdata),
      .i_q    (r_q),
      .i_pal  (r_pal),
      .o_byte (w_merged)
   );

`ifdef ATABLE_SKIP_SAME_EN
   logic r_skip;
   logic w_same;
   assign w_same = (mem_rdata[{r_q, 1'b0} +: 2] == r_pal);
`endif

   // State register, request latch, merge-result capture and reject pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_q      <= '0;
         r_pal    <= '0;
         r_merged <= '0;
         r_err    <= 1'b0;
`ifdef ATABLE_SKIP_SAME_EN
         r_skip   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_reject;
         // Rejected requests leave the address untouched so mem_addr keeps its last value.
         if (w_accept && !w_reject) begin
            r_addr <= AW'(addr_of(req_nt, req_row[4:2], req_col[4:2]));
            r_q    <= quad_of(req_row[1], req_col[1]);
            r_pal  <= req_pal;
         end
         if (r_state == WAIT) begin
            r_merged <= w_merged;
`ifdef ATABLE_SKIP_SAME_EN
            r_skip   <= w_same;
`endif
         end
      end
   end

   // Next state and memory strobes; reset squashes every strobe in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      mem_rd_en   = 1'b0;
      mem_we      = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_reject) w_state_nxt = RD;
         end
         RD: begin
            mem_rd_en   = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            w_state_nxt = WR;
         end
         WR: begin
            // An unchanged field still spends the WR slot so done timing never varies.
`ifdef ATABLE_SKIP_SAME_EN
            mem_we = !r_skip;
`else
            mem_we = 1'b1;
`endif
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (rst) begin
         w_state_nxt = IDLE;
         mem_rd_en   = 1'b0;
         mem_we      = 1'b0;
         done        = 1'b0;
      end
   end

endmodule

// File: tb/tb_atable_quad_writer.sv
// Bench for atable_quad_writer: directed vector table, reset-in-WAIT, then random updates.
// Owns a 128-byte registered-read RAM; expected bytes come from an arithmetic model.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_atable_quad_writer;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_nt;
   logic [4:0] req_col;
   logic [4:0] req_row;
   logic [1:0] req_pal;
   logic [6:0] mem_addr;
   logic       mem_rd_en;
   logic [7:0] mem_rdata;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic       done;
   logic       err;

   logic [7:0] ram [128];
   logic       bd_we;
   logic [6:0] bd_addr;
   logic [7:0] bd_dat;
   logic [7:0] model_mem [128];

   int checks;
   int errors;

   atable_quad_writer dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_nt    (req_nt),
      .req_col   (req_col),
      .req_row   (req_row),
      .req_pal   (req_pal),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attribute RAM with one-cycle registered read and a backdoor preload port.
   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_dat;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [6:0] a, input logic [7:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_dat  = d;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   // Issue one request at the current negedge (cycle N) and check cycles N+1..N+4.
   // rk != 0 asserts rst for one cycle starting after the sample of cycle N+rk.
   task automatic run_req(input string nm, input logic nt, input logic [4:0] col,
                          input logic [4:0] row, input logic [1:0] pal,
                          input logic [6:0] eaddr, input logic [7:0] ewd,
                          input bit rej, input bit ewe, input int rk);
      logic [3:0] a_rd, a_we, a_done, a_err, a_rdy;
      logic [3:0] e_rd, e_we, e_done, e_err, e_rdy;
      logic [6:0] addr1, addr3;
      logic [7:0] wd3;
      bit         overlap;
      chk({nm, ".ready_at_N"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_nt    = nt;
      req_col   = col;
      req_row   = row;
      req_pal   = pal;
      overlap   = 1'b0;
      addr1     = '0;
      addr3     = '0;
      wd3       = '0;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         a_rd[k-1]   = mem_rd_en;
         a_we[k-1]   = mem_we;
         a_done[k-1] = done;
         a_err[k-1]  = err;
         a_rdy[k-1]  = req_ready;
         if (mem_rd_en && mem_we) overlap = 1'b1;
         if (k == 1) addr1 = mem_addr;
         if (k == 3) begin
            addr3 = mem_addr;
            wd3   = mem_wdata;
         end
         if (k == 1) req_valid = 1'b0;
         if (rk != 0 && k == rk) rst = 1'b1;
         if (rk != 0 && k == rk + 1) rst = 1'b0;
      end
      if (rej) begin
         e_rd = 4'b0000; e_we = 4'b0000; e_done = 4'b0000; e_err = 4'b0001; e_rdy = 4'b1111;
      end else if (rk == 2) begin
         e_rd = 4'b0001; e_we = 4'b0000; e_done = 4'b0000; e_err = 4'b0000; e_rdy = 4'b1100;
      end else begin
         e_rd = 4'b0001; e_we = ewe ? 4'b0100 : 4'b0000; e_done = 4'b0100;
         e_err = 4'b0000; e_rdy = 4'b1000;
      end
      chk({nm, ".rd_en"}, 32'(a_rd), 32'(e_rd));
      chk({nm, ".we"}, 32'(a_we), 32'(e_we));
      chk({nm, ".done"}, 32'(a_done), 32'(e_done));
      chk({nm, ".err"}, 32'(a_err), 32'(e_err));
      chk({nm, ".ready"}, 32'(a_rdy), 32'(e_rdy));
      chk({nm, ".rd_we_overlap"}, 32'(overlap), 32'd0);
      if (!rej) begin
         chk({nm, ".rd_addr"}, 32'(addr1), 32'(eaddr));
         chk({nm, ".ram"}, 32'(ram[eaddr]), 32'(ewd));
      end
      if (!rej && rk == 0) begin
         chk({nm, ".wr_addr"}, 32'(addr3), 32'(eaddr));
         if (ewe) chk({nm, ".wdata"}, 32'(wd3), 32'(ewd));
      end
      if (rk == 2) begin
         chk({nm, ".addr_after_rst"}, 32'(addr3), 32'd0);
         chk({nm, ".wdata_after_rst"}, 32'(wd3), 32'd0);
      end
   endtask

   typedef struct {
      logic       nt;
      logic [4:0] col;
      logic [4:0] row;
      logic [1:0] pal;
      bit         pre;
      logic [7:0] init;
      logic [6:0] eaddr;
      logic [7:0] ewd;
      bit         rej;
      int         rk;
   } vec_t;

   vec_t tbl [11];

   initial begin
      bit         ewe;
      logic       nt;
      logic [4:0] col, row;
      logic [1:0] pal;
      int         a, q, sh, nb;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_nt    = 1'b0;
      req_col   = '0;
      req_row   = '0;
      req_pal   = '0;
      bd_we     = 1'b0;
      bd_addr   = '0;
      bd_dat    = '0;

      //             nt    col    row    pal   pre   init   eaddr  ewd    rej   rk
      tbl[0]  = '{1'b0, 5'd5,  5'd9,  2'd2, 1'b1, 8'h55, 7'h11, 8'h56, 1'b0, 0};
      tbl[1]  = '{1'b1, 5'd31, 5'd29, 2'd3, 1'b1, 8'h00, 7'h7F, 8'h0C, 1'b0, 0};
      tbl[2]  = '{1'b0, 5'd10, 5'd2,  2'd0, 1'b1, 8'hEA, 7'h02, 8'h2A, 1'b0, 0};
      tbl[3]  = '{1'b0, 5'd3,  5'd30, 2'd1, 1'b0, 8'h00, 7'h00, 8'h00, 1'b1, 0};
      tbl[4]  = '{1'b1, 5'd0,  5'd31, 2'd0, 1'b0, 8'h00, 7'h00, 8'h00, 1'b1, 0};
      tbl[5]  = '{1'b0, 5'd0,  5'd0,  2'd1, 1'b1, 8'h00, 7'h00, 8'h01, 1'b0, 0};
      tbl[6]  = '{1'b0, 5'd2,  5'd2,  2'd2, 1'b0, 8'h00, 7'h00, 8'h81, 1'b0, 0};
      tbl[7]  = '{1'b0, 5'd8,  5'd4,  2'd3, 1'b1, 8'h3C, 7'h0A, 8'h3C, 1'b0, 2};
      tbl[8]  = '{1'b0, 5'd4,  5'd0,  2'd1, 1'b1, 8'h55, 7'h01, 8'h55, 1'b0, 0};
      tbl[9]  = '{1'b1, 5'd1,  5'd3,  2'd1, 1'b1, 8'hFF, 7'h40, 8'hDF, 1'b0, 0};
      tbl[10] = '{1'b0, 5'd0,  5'd29, 2'd2, 1'b1, 8'hA0, 7'h38, 8'hA2, 1'b0, 0};

      repeat (3) @(negedge clk);
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst.we", 32'(mem_we), 32'd0);
      chk("rst.addr", 32'(mem_addr), 32'd0);
      chk("rst.wdata", 32'(mem_wdata), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst.ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 11; i++) begin
         if (tbl[i].pre) preload(tbl[i].eaddr, tbl[i].init);
`ifdef ATABLE_SKIP_SAME_EN
         ewe = (tbl[i].ewd != ram[tbl[i].eaddr]);
`else
         ewe = 1'b1;
`endif
         run_req($sformatf("vec%0d", i), tbl[i].nt, tbl[i].col, tbl[i].row, tbl[i].pal,
                 tbl[i].eaddr, tbl[i].ewd, tbl[i].rej, ewe, tbl[i].rk);
      end

      // Random phase: fill the whole RAM, then stream back-to-back random updates.
      for (int i = 0; i < 128; i++) begin
         model_mem[i] = 8'($urandom);
         preload(7'(i), model_mem[i]);
      end
      for (int n = 0; n < 250; n++) begin
         nt  = 1'($urandom_range(0, 1));
         col = 5'($urandom_range(0, 31));
         row = 5'($urandom_range(0, 31));
         pal = 2'($urandom_range(0, 3));
         if (int'(row) > 29) begin
            run_req($sformatf("rnd%0d", n), nt, col, row, pal, 7'd0, 8'd0, 1'b1, 1'b0, 0);
         end else begin
            a  = int'(nt) * 64 + (int'(row) / 4) * 8 + int'(col) / 4;
            q  = ((int'(row) / 2) % 2) * 2 + (int'(col) / 2) % 2;
            sh = 2 * q;
            nb = (int'(model_mem[a]) & ~(3 << sh)) | (int'(pal) << sh);
`ifdef ATABLE_SKIP_SAME_EN
            ewe = (8'(nb) != model_mem[a]);
`else
            ewe = 1'b1;
`endif
            model_mem[a] = 8'(nb);
            run_req($sformatf("rnd%0d", n), nt, col, row, pal, 7'(a), 8'(nb), 1'b0, ewe, 0);
         end
      end
      for (int i = 0; i < 128; i++) begin
         chk($sformatf("final_ram[%0d]", i), 32'(ram[i]), 32'(model_mem[i]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
